// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor/accumulator:
// op encoding and the pipeline stage record carried between register stages.
package addsub_pkg;

    // Widest operand the pipeline supports; stage records are sized for it.
    localparam int MAX_WIDTH = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH:0]   res;
    } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the result pipeline. It advances only when enabled;
// the payload is kept when a bubble passes so the output holds its last value.
module pipe_stage
    import addsub_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);

    stage_t data_q;
    stage_t data_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        data_d = data_q;
        if (en) begin
            data_d.valid = d.valid;
            if (d.valid) begin
                data_d.res = d.res;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined unsigned add/subtract/accumulate with valid/ready on both sides.
// Stage 1 computes at acceptance; LATENCY-1 further register stages follow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic             acc_ovf
);

    logic             stall;
    logic             advance;
    logic             accept;
    logic [WIDTH:0]   result;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             acc_ovf_q;
    logic             acc_ovf_d;
    stage_t           stage1_q;
    stage_t           stage1_d;

    stage_t           chain [LATENCY];
    logic             unused_res_hi;

    // A stalled output freezes every stage, so no bubble is ever squeezed out.
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        result    = '0;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        if (accept) begin
            case (op)
                OP_ADD: result = {1'b0, a} + {1'b0, b};
                OP_SUB: result = {1'b0, a} - {1'b0, b};
                OP_ACC: begin
                    result = {1'b0, acc_q} + {1'b0, a};
                    acc_d  = result[WIDTH-1:0];
                    if (result[WIDTH]) begin
                        acc_ovf_d = 1'b1;
                    end
                end
                default: begin
                    result    = '0;
                    acc_d     = '0;
                    acc_ovf_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stage1_d = stage1_q;
        if (advance) begin
            stage1_d.valid = accept;
            if (accept) begin
                stage1_d.res            = '0;
                stage1_d.res[WIDTH:0]   = result;
            end
        end
    end

    // The accumulator updates at acceptance, so chained ACC ops see no hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            stage1_q  <= '0;
        end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            stage1_q  <= stage1_d;
        end
    end

    assign chain[0] = stage1_q;

    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        pipe_stage u_stage (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .d   (chain[i-1]),
            .q   (chain[i])
        );
    end

    assign out_valid     = chain[LATENCY-1].valid;
    assign s             = chain[LATENCY-1].res[WIDTH:0];
    assign acc_ovf       = acc_ovf_q;
    assign unused_res_hi = ^chain[LATENCY-1].res;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: an 8-bit/latency-2 and a 16-bit/latency-1 instance
// checked every cycle against an in-flight queue model, plus literal cases.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int W0 = 8;
    localparam int L0 = 2;
    localparam int W1 = 16;
    localparam int L1 = 1;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  acc_ovf;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [8:0]  s0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [16:0] s1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Model state per instance: results in flight with their age in pipeline advances.
    int unsigned q_res [2][8];
    int          q_age [2][8];
    int          q_n   [2];
    int unsigned acc_m [2];
    bit          ovf_m [2];
    int unsigned last_s[2];
    int unsigned got0[$];

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W0), .LATENCY(L0)) u_dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .op        (op0),
        .a         (a0),
        .b         (b0),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .s         (s0),
        .acc_ovf   (acc_ovf[0])
    );

    addsub_pipe #(.WIDTH(W1), .LATENCY(L1)) u_dut1 (
        .clk       (clk),
        .rst       (rst[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .op        (op1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .s         (s1),
        .acc_ovf   (acc_ovf[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned mdl_res(input logic [1:0] o, input int unsigned x,
                                            input int unsigned y, input int unsigned acc,
                                            input int w);
        int unsigned m;
        m = 32'd1 << (w + 1);
        case (o)
            OP_ADD:  return (x + y) % m;
            OP_SUB:  return (x + m - y) % m;
            OP_ACC:  return (acc + x) % m;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin : p_monitor
        int          w;
        int          lat;
        bit          exp_ov;
        bit          stall;
        int unsigned r;
        int unsigned sv;
        int unsigned xv;
        int unsigned yv;
        logic [1:0]  ov;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                w      = (d == 0) ? W0 : W1;
                lat    = (d == 0) ? L0 : L1;
                sv     = (d == 0) ? 32'(s0) : 32'(s1);
                xv     = (d == 0) ? 32'(a0) : 32'(a1);
                yv     = (d == 0) ? 32'(b0) : 32'(b1);
                ov     = (d == 0) ? op0 : op1;
                exp_ov = (q_n[d] > 0) && (q_age[d][0] == lat);
                stall  = exp_ov && !out_ready[d];
                check($sformatf("d%0d out_valid", d), 64'(out_valid[d]), 64'(exp_ov));
                check($sformatf("d%0d in_ready", d), 64'(in_ready[d]), 64'(!stall));
                check($sformatf("d%0d acc_ovf", d), 64'(acc_ovf[d]), 64'(ovf_m[d]));
                if (exp_ov) check($sformatf("d%0d s", d), 64'(sv), 64'(q_res[d][0]));
                else        check($sformatf("d%0d s_hold", d), 64'(sv), 64'(last_s[d]));
                if (d == 0 && !rst[0] && out_valid[0] && out_ready[0]) got0.push_back(sv);
                if (rst[d]) begin
                    q_n[d] = 0; acc_m[d] = 0; ovf_m[d] = 1'b0; last_s[d] = 0;
                end else if (!stall) begin
                    if (exp_ov) begin
                        for (int i = 0; i < q_n[d] - 1; i++) begin
                            q_res[d][i] = q_res[d][i+1];
                            q_age[d][i] = q_age[d][i+1];
                        end
                        q_n[d]--;
                    end
                    for (int i = 0; i < q_n[d]; i++) q_age[d][i]++;
                    if (in_valid[d] && q_n[d] < 8) begin
                        r = mdl_res(ov, xv, yv, acc_m[d], w);
                        if (ov == OP_ACC) begin
                            acc_m[d] = r % (32'd1 << w);
                            if ((r >> w) != 0) ovf_m[d] = 1'b1;
                        end else if (ov == OP_CLR) begin
                            acc_m[d] = 0;
                            ovf_m[d] = 1'b0;
                        end
                        q_res[d][q_n[d]] = r;
                        q_age[d][q_n[d]] = 1;
                        q_n[d]++;
                    end
                    if (q_n[d] > 0 && q_age[d][0] == lat) last_s[d] = q_res[d][0];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue0(input logic [1:0] o, input int unsigned x, input int unsigned y);
        int n;
        in_valid[0] = 1'b1;
        op0 = o;
        a0  = 8'(x);
        b0  = 8'(y);
        n   = 0;
        @(negedge clk);
        while (!in_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("issue0 in_ready wait", 64'(in_ready[0]), 64'd1);
        step();
        in_valid[0] = 1'b0;
    endtask

    task automatic rand_stream(input int d);
        int          n_acc;
        int          cyc;
        int unsigned x;
        int unsigned y;
        int unsigned k;
        logic [1:0]  o;
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            out_ready[d] = ($urandom_range(0, 3) != 0);
            in_valid[d]  = ($urandom_range(0, 4) != 0);
            k = $urandom_range(0, 15);
            o = (k == 0) ? OP_CLR : 2'(k % 3);
            x = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (d == 0) begin
                op0 = o; a0 = 8'(x); b0 = 8'(y);
            end else begin
                op1 = o; a1 = 16'(x); b1 = 16'(y);
            end
            @(negedge clk);
            if (in_valid[d] && in_ready[d]) n_acc++;
            step();
            cyc++;
        end
        check($sformatf("d%0d stream ops accepted", d), 64'(n_acc), 64'd1000);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; in_valid = 2'b00; out_ready = 2'b11;
        op0 = OP_ADD; a0 = '0; b0 = '0;
        op1 = OP_ADD; a1 = '0; b1 = '0;

        check("pin model sub", 64'(mdl_res(OP_SUB, 5, 10, 0, 8)), 64'h1FB);
        check("pin model acc", 64'(mdl_res(OP_ACC, 10, 0, 250, 8)), 64'h104);
        check("pin model add16", 64'(mdl_res(OP_ADD, 32'hFFFF, 1, 0, 16)), 64'h10000);

        step();
        mon_en = 1'b1;
        step();
        rst = 2'b00;
        check("reset in_ready", 64'(in_ready[0]), 64'd1);
        check("reset s", 64'(s0), 64'd0);

        // ADD with carry-out, latency 2
        issue0(OP_ADD, 200, 100);
        check("t1 out_valid early", 64'(out_valid[0]), 64'd0);
        step();
        check("t1 out_valid", 64'(out_valid[0]), 64'd1);
        check("t1 s", 64'(s0), 64'h12C);
        step();
        check("t1 out_valid after", 64'(out_valid[0]), 64'd0);
        check("t1 s hold", 64'(s0), 64'h12C);

        // Back-to-back SUB with and without borrow
        issue0(OP_SUB, 5, 10);
        issue0(OP_SUB, 10, 5);
        check("t2 s borrow", 64'(s0), 64'h1FB);
        step();
        check("t2 s second", 64'(s0), 64'h005);
        check("t2 out_valid second", 64'(out_valid[0]), 64'd1);
        repeat (3) step();

        // Accumulator chain with sticky overflow
        got0.delete();
        issue0(OP_CLR, 0, 0);
        issue0(OP_ACC, 250, 0);
        check("t3 ovf after 250", 64'(acc_ovf[0]), 64'd0);
        issue0(OP_ACC, 10, 0);
        check("t3 ovf set", 64'(acc_ovf[0]), 64'd1);
        issue0(OP_ACC, 3, 0);
        check("t3 ovf sticky", 64'(acc_ovf[0]), 64'd1);
        repeat (4) step();
        check("t3 count", 64'(got0.size()), 64'd4);
        if (got0.size() == 4) begin
            check("t3 r0", 64'(got0[0]), 64'h000);
            check("t3 r1", 64'(got0[1]), 64'd250);
            check("t3 r2", 64'(got0[2]), 64'h104);
            check("t3 r3", 64'(got0[3]), 64'd7);
        end
        issue0(OP_CLR, 0, 0);
        check("t3 ovf cleared", 64'(acc_ovf[0]), 64'd0);
        repeat (3) step();

        // Backpressure: pipeline holds, then releases in order
        got0.delete();
        out_ready[0] = 1'b0;
        issue0(OP_ADD, 1, 1);
        issue0(OP_ADD, 2, 2);
        in_valid[0] = 1'b1; op0 = OP_ADD; a0 = 8'd3; b0 = 8'd3;
        for (int i = 0; i < 3; i++) begin
            check("t4 in_ready stalled", 64'(in_ready[0]), 64'd0);
            check("t4 s held", 64'(s0), 64'd2);
            step();
        end
        out_ready[0] = 1'b1;
        #1;
        check("t4 in_ready released", 64'(in_ready[0]), 64'd1);
        step();
        in_valid[0] = 1'b0;
        repeat (4) step();
        check("t4 count", 64'(got0.size()), 64'd3);
        if (got0.size() == 3) begin
            check("t4 r0", 64'(got0[0]), 64'd2);
            check("t4 r1", 64'(got0[1]), 64'd4);
            check("t4 r2", 64'(got0[2]), 64'd6);
        end

        // Reset discards the in-flight result and clears acc/ovf
        issue0(OP_ACC, 255, 0);
        issue0(OP_ACC, 5, 0);
        check("t5 ovf before rst", 64'(acc_ovf[0]), 64'd1);
        repeat (3) step();
        got0.delete();
        issue0(OP_ADD, 7, 8);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        check("t5 out_valid", 64'(out_valid[0]), 64'd0);
        check("t5 ovf", 64'(acc_ovf[0]), 64'd0);
        repeat (3) step();
        check("t5 nothing emitted", 64'(got0.size()), 64'd0);
        issue0(OP_ACC, 1, 0);
        repeat (3) step();
        check("t5 next count", 64'(got0.size()), 64'd1);
        if (got0.size() == 1) check("t5 acc restarted", 64'(got0[0]), 64'd1);

        // 16-bit, latency 1: full carry-out
        in_valid[1] = 1'b1; op1 = OP_ADD; a1 = 16'hFFFF; b1 = 16'h0001;
        @(negedge clk);
        step();
        in_valid[1] = 1'b0;
        check("t6 out_valid", 64'(out_valid[1]), 64'd1);
        check("t6 s", 64'(s1), 64'h10000);
        step();
        check("t6 out_valid after", 64'(out_valid[1]), 64'd0);

        // Random streaming on both instances against the model
        fork
            rand_stream(0);
            rand_stream(1);
        join
        repeat (8) step();
        check("drain d0", 64'(out_valid[0]), 64'd0);
        check("drain d1", 64'(out_valid[1]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined unsigned adder/subtractor/accumulator with valid/ready handshake on input and output.
- Successor to the team's fixed 8-bit registered adder: adds configurable width and latency, a subtract mode, a running-accumulator mode, backpressure and a sticky overflow flag.
- Sits behind the board clock wizard output.
- Feeds downstream datapath or display logic on one clock domain.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- LATENCY, 2, cycles from input acceptance to out_valid (1..4); stage 1 computes, stages 2..LATENCY are register stages.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op valid.
- in_ready  out  1  block can accept this cycle.
- op  in  2  00=ADD A+B, 01=SUB A-B, 10=ACC acc+A, 11=CLR acc<=0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for ACC/CLR).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH+1  result; MSB = carry (ADD/ACC) or borrow (SUB).
- acc_ovf  out  1  sticky: set when any ACC produces carry; cleared by CLR or rst.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - all pipeline valid bits cleared; out_valid=0; s=0; acc=0; acc_ovf=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight results; nothing is emitted.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from registered out_valid and out_ready.
  - While stalled, the whole pipeline holds: s stable, out_valid stays high, acc does not update.
  - Bubbles do not compress. Full throughput of 1 op/cycle applies when out_ready=1.
- Latency: an input accepted at edge k with no stalls gives out_valid=1 and the matching s after edge k+LATENCY-1. LATENCY=1 means the result is visible the cycle after acceptance.
- Arithmetic in stage 1, at acceptance:
  - ADD: s = {1'b0,a} + {1'b0,b}.
  - SUB: s = {1'b0,a} - {1'b0,b}, modulo 2^(WIDTH+1). s[WIDTH]=1 iff a<b; low bits are the two's-complement difference.
  - ACC: t = {1'b0,acc} + {1'b0,a}; acc <= t[WIDTH-1:0], wrapping; s = t; if t[WIDTH] then acc_ovf <= 1.
  - CLR: acc <= 0; acc_ovf <= 0; s = 0; a result is still emitted (out_valid pulses) so sequence order is preserved.
- Accumulator ordering:
  - acc updates at acceptance, so back-to-back ACC ops chain correctly with no hazard.
  - CLR followed immediately by ACC uses acc=0.
- acc_ovf changes at acceptance of the causing op, not at output. It does not stall with the output.
- Simultaneous events:
  - rst has priority over everything.
  - An output transfer and a new acceptance in the same cycle is legal and expected. The pipeline shifts, so out_valid stays 1 if the next stage is valid.
- No X on outputs after reset; s holds its last value when out_valid=0.

Decomposition:
- Package addsub_pkg:
  - op encoding localparams OP_ADD, OP_SUB, OP_ACC, OP_CLR (2-bit).
  - typedef/struct for a pipeline stage: valid bit plus WIDTH+1 result.
- Sub-module pipe_stage:
  - one register stage with valid bit and enable = !stall.
  - instantiated LATENCY-1 times via generate.
  - stage 1 compute logic stays in the top.

Test Plan (WIDTH=8, LATENCY=2 unless stated):
1. Reset then ADD a=200,b=100, out_ready=1 -> out_valid rises 2 cycles after acceptance edge; s=9'h12C (300), MSB=1.
2. SUB a=5,b=10 then SUB a=10,b=5, back-to-back -> s=9'h1FB (borrow=1, low=0xFB), then s=9'h005; one result per cycle.
3. CLR; ACC a=250; ACC a=10; ACC a=3 -> s=0, then 250, then 9'h104 with acc_ovf=1 and acc=4, then 7; acc_ovf stays 1. A following CLR drops acc_ovf to 0.
4. Hold out_ready=0 with 3 ops issued (ADD 1+1, 2+2, 3+3) -> in_ready drops once out_valid=1; s holds 2 unchanged. Releasing out_ready yields 2, 4, 6 in order, with no loss or duplication.
5. Assert rst one cycle after accepting ADD 7+8 -> no result emitted; out_valid=0; acc=0; next op works normally.
6. LATENCY=1 and WIDTH=16: ADD 0xFFFF+1 -> s=17'h10000 one cycle after acceptance. Random streaming of 1000 ops with random out_ready is checked against a scoreboard model.
